eth_fcs_tx_ctrl: RTL and testbench

ETH_FCS_TX_CTRL -- requirements
Module: eth_fcs_tx_ctrl

---
 rtl/eth_fcs_tx_ctrl.sv | 126 ++++++++++++
 tb/tb_eth_fcs_tx_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_fcs_tx_ctrl.sv
// rtl/eth_fcs_tx_ctrl.sv - Ethernet TX FCS appender: registered byte stream, CRC-32 trailer
// Optional zero-padding of short frames to MIN_LEN when ETH_FCS_PAD_EN is defined.
module eth_fcs_tx_ctrl #(
  parameter int MIN_LEN = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

  state_t      state;
  logic [31:0] crc;
  logic [11:0] cnt;
  logic [2:0]  fcs_idx;
  logic        out_free;
  logic        accept;
  logic [11:0] cnt_inc;
  logic [31:0] crc_data;
  logic [31:0] fcs;
  logic        pad_needed;

  if (MIN_LEN < 1 || MIN_LEN > 4095) begin : g_min_len_check
    $error("eth_fcs_tx_ctrl: MIN_LEN must be within 1..4095");
  end

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Output register may be reloaded when empty or when its byte is being taken.
  assign out_free = !m_valid || m_ready;
  assign s_ready  = (state == IDLE || state == DATA) && out_free;
  assign accept   = s_valid && s_ready;
  assign busy     = (state != IDLE);
  assign cnt_inc  = (cnt == 12'hFFF) ? cnt : cnt + 12'd1;
  assign crc_data = crc_byte(crc, s_data);
  assign fcs      = ~crc;

`ifdef ETH_FCS_PAD_EN
  logic [31:0] crc_pad;
  logic        pad_done;
  assign crc_pad    = crc_byte(crc, 8'h00);
  assign pad_needed = int'(cnt_inc) < MIN_LEN;
  assign pad_done   = int'(cnt_inc) >= MIN_LEN;
`else
  assign pad_needed = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      crc        <= 32'hFFFFFFFF;
      cnt        <= 12'd0;
      fcs_idx    <= 3'd0;
      m_data     <= 8'h00;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE, DATA: begin
          if (accept) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            crc     <= crc_data;
            cnt     <= cnt_inc;
            if (s_last) state <= pad_needed ? PAD : FCS;
            else        state <= DATA;
          end else if (out_free) begin
            m_valid <= 1'b0;
          end
        end
`ifdef ETH_FCS_PAD_EN
        PAD: begin
          if (out_free) begin
            m_data  <= 8'h00;
            m_valid <= 1'b1;
            crc     <= crc_pad;
            cnt     <= cnt_inc;
            if (pad_done) state <= FCS;
          end
        end
`endif
        FCS: begin
          if (out_free) begin
            // fcs_idx == 4 means the m_last byte is the one handshaking now.
            if (fcs_idx == 3'd4) begin
              state      <= IDLE;
              m_valid    <= 1'b0;
              m_last     <= 1'b0;
              fcs_idx    <= 3'd0;
              crc        <= 32'hFFFFFFFF;
              cnt        <= 12'd0;
              frame_done <= 1'b1;
            end else begin
              m_data  <= fcs[8*fcs_idx[1:0] +: 8];
              m_valid <= 1'b1;
              m_last  <= (fcs_idx == 3'd3);
              fcs_idx <= fcs_idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_fcs_tx_ctrl.sv
// tb/tb_eth_fcs_tx_ctrl.sv - self-checking bench for eth_fcs_tx_ctrl (either ETH_FCS_PAD_EN build)
`timescale 1ns/1ps
module tb_eth_fcs_tx_ctrl;
  localparam int MIN_LEN = 60;
`ifdef ETH_FCS_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready = 1'b1;
  logic       busy;
  logic       frame_done;

  eth_fcs_tx_ctrl #(.MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  typedef struct {
    int          len;
    logic [7:0]  first;
    logic [7:0]  step;
    bit          tog;
    logic [31:0] k_fcs;
    bit          k_valid;
    int          xfers;
    int          xfers_pad;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vecs[6];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          xfer_cnt = 0;
  int          mlast_seen = 0;
  int          last_xfer_cyc = -100;
  int          first_acc_cyc = 0;
  int          gap_ref = 0;
  logic [31:0] cap_fcs = 32'h0;
  bit          ignore = 1'b0;
  bit          in_tail = 1'b0;
  bit          tog = 1'b0;
  bit          prev_last = 1'b0;
  bit          want_first = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    m_ready = tog ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (prev_last || frame_done) check("frame_done", frame_done, prev_last);
      prev_last = 1'b0;
      if (in_tail) check("s_ready_tail", s_ready, 0);
      if (s_valid && s_ready && s_last) in_tail = 1'b1;
      if (want_first && s_valid && s_ready) begin
        first_acc_cyc = cyc;
        gap_ref       = last_xfer_cyc;
        want_first    = 1'b0;
      end
      if (m_valid && m_ready) begin
        xfer_cnt++;
        cap_fcs = {m_data, cap_fcs[31:8]};
        if (m_last) begin
          mlast_seen++;
          prev_last     = 1'b1;
          last_xfer_cyc = cyc;
          in_tail       = 1'b0;
        end
        if (!ignore) begin
          if (sb.size() == 0) begin
            check("sb_extra_byte", {23'd0, m_last, m_data}, 32'hFFFF_FFFF);
          end else begin
            mon_e = sb.pop_front();
            check("sb_data", m_data, mon_e.d);
            check("sb_last", m_last, mon_e.l);
          end
        end
      end
    end else begin
      prev_last = 1'b0;
      in_tail   = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = l;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 1000);
    if (!s_ready) check("s_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int len, input logic [7:0] first, input logic [7:0] step);
    logic [31:0] c;
    logic [7:0]  b;
    int          npad;
    c = 32'hFFFFFFFF;
    b = first;
    for (int i = 0; i < len; i++) begin
      sb.push_back('{d: b, l: 1'b0});
      c = crc_upd(c, b);
      b = b + step;
    end
    npad = (PAD_ON && len < MIN_LEN) ? MIN_LEN - len : 0;
    for (int i = 0; i < npad; i++) begin
      sb.push_back('{d: 8'h00, l: 1'b0});
      c = crc_upd(c, 8'h00);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) sb.push_back('{d: c[8*k +: 8], l: (k == 3)});
    b = first;
    for (int i = 0; i < len; i++) begin
      send_byte(b, i == len - 1);
      b = b + step;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n >= 3000), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{9,  8'h31, 8'h01, 1'b0, 32'hCBF43926, 1'b1, 13, 64};
    vecs[1] = '{9,  8'h31, 8'h01, 1'b1, 32'hCBF43926, 1'b1, 13, 64};
    vecs[2] = '{1,  8'h00, 8'h00, 1'b0, 32'hD202EF8D, 1'b1, 5,  64};
    vecs[3] = '{1,  8'h61, 8'h00, 1'b1, 32'hE8B7BE43, 1'b1, 5,  64};
    vecs[4] = '{60, 8'h00, 8'h01, 1'b0, 32'h0,        1'b0, 64, 64};
    vecs[5] = '{70, 8'hA5, 8'h03, 1'b1, 32'h0,        1'b0, 74, 74};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[v]) begin
      tog      = vecs[v].tog;
      xfer_cnt = 0;
      send_frame(vecs[v].len, vecs[v].first, vecs[v].step);
      s_valid = 1'b0;
      s_last  = 1'b0;
      wait_drain();
      tog = 1'b0;
      check("xfer_count", xfer_cnt, PAD_ON ? vecs[v].xfers_pad : vecs[v].xfers);
      if (vecs[v].k_valid && (!PAD_ON || vecs[v].len >= MIN_LEN))
        check("fcs_known", cap_fcs, vecs[v].k_fcs);
    end

    // Abort a 20-byte frame with rst on its 5th byte, then send a clean frame.
    ignore     = 1'b1;
    mlast_seen = 0;
    for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 1'b0);
    s_data  = 8'h44;
    s_valid = 1'b1;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("abort_m_valid", m_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_m_last", m_last, 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_fcs", mlast_seen, 0);
    ignore   = 1'b0;
    xfer_cnt = 0;
    send_frame(9, 8'h31, 8'h01);
    s_valid = 1'b0;
    s_last  = 1'b0;
    wait_drain();
    check("post_abort_fcs", cap_fcs, PAD_ON ? cap_fcs : 32'hCBF43926);
    check("post_abort_xfers", xfer_cnt, PAD_ON ? 64 : 13);
    check("post_abort_mlast", mlast_seen, 1);

    // Back-to-back frames with s_valid held high across the FCS tail.
    xfer_cnt = 0;
    send_frame(9, 8'h31, 8'h01);
    want_first = 1'b1;
    send_frame(9, 8'h31, 8'h01);
    s_valid = 1'b0;
    s_last  = 1'b0;
    wait_drain();
    check("b2b_gap", first_acc_cyc - gap_ref, 1);
    check("b2b_xfers", xfer_cnt, PAD_ON ? 128 : 26);
    check("b2b_fcs", cap_fcs, PAD_ON ? cap_fcs : 32'hCBF43926);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
